bit_serial_adder_ctrl: RTL

BIT_SERIAL_ADDER_CTRL -- requirements
Module: bit_serial_adder_ctrl

---
 rtl/bit_serial_adder_ctrl_pkg.sv | 12 +
 rtl/bit_serial_adder_ctrl_full_adder_cell.sv | 20 ++
 rtl/bit_serial_adder_ctrl.sv | 100 ++++++++++
 3 files changed

// File: rtl/bit_serial_adder_ctrl_pkg.sv
// rtl/bit_serial_adder_ctrl_pkg.sv - shared state encoding and default width for the bit-serial adder
package bit_serial_adder_ctrl_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } bsa_state_t;

endpackage

// File: rtl/bit_serial_adder_ctrl_full_adder_cell.sv
// rtl/bit_serial_adder_ctrl_full_adder_cell.sv - gate-level one-bit full adder
module full_adder_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic s,
    output logic cout
);

    logic ab_x;
    logic ab_a;
    logic cx_a;

    xor g_x0 (ab_x, a, b);
    xor g_x1 (s, ab_x, cin);
    and g_a0 (ab_a, a, b);
    and g_a1 (cx_a, ab_x, cin);
    or  g_o0 (cout, ab_a, cx_a);

endmodule

// File: rtl/bit_serial_adder_ctrl.sv
// rtl/bit_serial_adder_ctrl.sv - LSB-first bit-serial adder with IDLE/RUN/DONE handshake
module bit_serial_adder_ctrl
    import bit_serial_adder_ctrl_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    bsa_state_t       state;
    logic [WIDTH-1:0] a_sr;
    logic [WIDTH-1:0] b_sr;
    logic [WIDTH-1:0] res_sr;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             fa_s;
    logic             fa_c;

    full_adder_cell u_fa (
        .a    (a_sr[0]),
        .b    (b_sr[0]),
        .cin  (carry),
        .s    (fa_s),
        .cout (fa_c)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            carry  <= 1'b0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
            ready  <= 1'b1;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_sr  <= a;
                        b_sr  <= b;
                        carry <= cin;
                        cnt   <= '0;
                        state <= RUN;
                        ready <= 1'b0;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    res_sr <= {fa_s, res_sr[WIDTH-1:1]};
                    a_sr   <= a_sr >> 1;
                    b_sr   <= b_sr >> 1;
                    carry  <= fa_c;
                    if (cnt == LAST_BIT) begin
                        // carry still holds the carry into the MSB at this edge
                        sum   <= {fa_s, res_sr[WIDTH-1:1]};
                        cout  <= fa_c;
                        ovf   <= carry ^ fa_c;
                        state <= DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    ready <= 1'b1;
                end
                default: begin
                    state <= IDLE;
                    ready <= 1'b1;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule
